keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 33 +++
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared state encoding, matrix size and helpers for the 4x4 scanner.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int KP_LINES = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_t;

  function automatic int kp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [KP_LINES-1:0] kp_col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

  // Lowest-index active-low row wins when several keys share a column.
  function automatic logic [1:0] kp_first_low(input logic [KP_LINES-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = KP_LINES - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Generic two-flop synchronizer for asynchronous input buses.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad scanner with debounce; optional auto-repeat
//            enabled by defining KEYPAD_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [KP_LINES-1:0] row_in,
  output logic [KP_LINES-1:0] col_out,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int                 C_CNT_MAX  = kp_max(kp_max(SCAN_DIV, DEBOUNCE_CYCLES), 2);
  localparam int                 C_CNT_W    = $clog2(C_CNT_MAX);
  localparam logic [C_CNT_W-1:0] C_CNT_SAT  = '1;
  localparam logic [C_CNT_W-1:0] C_SCAN_LST = C_CNT_W'(SCAN_DIV - 1);
  localparam logic [C_CNT_W-1:0] C_DEB_LST  = C_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KP_LINES-1:0] w_rows_s;
  logic                w_rows_idle;
  logic [C_CNT_W-1:0]  w_cnt_inc;
  logic [1:0]          w_col_nxt;
  logic                w_rep_fire;

  kp_state_t           r_state;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [1:0]          r_col;
  logic [KP_LINES-1:0] r_col_out;
  logic [KP_LINES-1:0] r_pat;
  logic [3:0]          r_code;
  logic                r_valid;
  logic                r_held;

  sync_2ff #(
    .WIDTH   (KP_LINES),
    .RST_VAL ({KP_LINES{1'b1}})
  ) u_row_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (row_in),
    .o_q     (w_rows_s)
  );

  assign w_rows_idle = (w_rows_s == {KP_LINES{1'b1}});
  assign w_cnt_inc   = (r_cnt == C_CNT_SAT) ? r_cnt : r_cnt + 1'b1;
  assign w_col_nxt   = r_col + 2'd1;

`ifdef KEYPAD_REPEAT_EN
  localparam int                 C_REP_W   = $clog2(kp_max(kp_max(REPEAT_DELAY, REPEAT_PERIOD), 2));
  localparam logic [C_REP_W-1:0] C_REP_SAT = '1;
  localparam logic [C_REP_W-1:0] C_DLY_LST = C_REP_W'(REPEAT_DELAY - 1);
  localparam logic [C_REP_W-1:0] C_PER_LST = C_REP_W'(REPEAT_PERIOD - 1);

  logic [C_REP_W-1:0] r_rep;
  logic               r_rep_first;

  assign w_rep_fire = (r_state == ST_HELD) && !w_rows_idle &&
                      (r_rep == (r_rep_first ? C_DLY_LST : C_PER_LST));

  // Counter freezes while a release is being debounced and restarts on any return to HELD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rep       <= '0;
      r_rep_first <= 1'b1;
    end else if (r_state == ST_HELD) begin
      if (w_rep_fire) begin
        r_rep       <= '0;
        r_rep_first <= 1'b0;
      end else if (!w_rows_idle) begin
        r_rep <= (r_rep == C_REP_SAT) ? r_rep : r_rep + 1'b1;
      end
    end else if (r_state != ST_RELEASE || !w_rows_idle) begin
      r_rep       <= '0;
      r_rep_first <= 1'b1;
    end
  end
`else
  logic w_unused_rep;
  assign w_unused_rep = (REPEAT_DELAY != REPEAT_PERIOD);
  assign w_rep_fire   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_SCAN;
      r_cnt     <= '0;
      r_col     <= 2'd0;
      r_col_out <= 4'b1110;
      r_pat     <= '1;
      r_code    <= 4'd0;
      r_valid   <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (r_cnt != C_SCAN_LST) begin
            r_cnt <= w_cnt_inc;
          end else begin
            r_cnt <= '0;
            if (w_rows_idle) begin
              r_col     <= w_col_nxt;
              r_col_out <= kp_col_drive(w_col_nxt);
            end else begin
              r_pat   <= w_rows_s;
              r_state <= ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (w_rows_s != r_pat) begin
            r_state   <= ST_SCAN;
            r_cnt     <= '0;
            r_col     <= w_col_nxt;
            r_col_out <= kp_col_drive(w_col_nxt);
          end else if (r_cnt == C_DEB_LST) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_code  <= {kp_first_low(r_pat), r_col};
            r_held  <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_HELD: begin
          if (w_rows_idle) begin
            r_state <= ST_RELEASE;
            r_cnt   <= '0;
          end else if (w_rep_fire) begin
            r_valid <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!w_rows_idle) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == C_DEB_LST) begin
            r_state   <= ST_SCAN;
            r_cnt     <= '0;
            r_held    <= 1'b0;
            r_col     <= w_col_nxt;
            r_col_out <= kp_col_drive(w_col_nxt);
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign col_out   = r_col_out;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Scoreboard bench for keypad_scanner with a 4x4 key-matrix model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int RDLY     = 40;
  localparam int RPER     = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;   // bit r*4+c closes the switch between row r and column c
  logic [3:0]  exp_q[$];
  int          pulse_t[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [3:0]  last_code;
  logic [3:0]  mon_e;
  logic [3:0]  col_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int col, input logic [3:0] mask);
    for (int r = 0; r < 4; r++) pressed[r*4+col] = mask[r];
  endtask

  function automatic logic [3:0] model_code(input int col, input logic [3:0] mask);
    int row;
    row = 0;
    for (int r = 3; r >= 0; r--) if (mask[r]) row = r;
    return 4'(row * 4 + col);
  endfunction

  // Monitor: every key_valid pulse consumes one expected code.
  always @(negedge clk) begin
    if (reset_n && key_valid === 1'b1) begin
      pulse_t.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_key_valid: got code %b, expected no pulse", key_code);
      end else begin
        mon_e = exp_q.pop_front();
        if (key_code !== mon_e) begin
          bad++;
          $display("FAIL key_code_on_valid: got %b expected %b", key_code, mon_e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int exp_off[$];
    int off;
    int col;
    logic [3:0] mask;
    logic [3:0] seen;
    logic [3:0] code;

    pressed   = '0;
    last_code = 4'd0;
    cycles(3);
    check("rst_col_out", col_out, 4'b1110);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held", key_held, 1'b0);
    check("rst_key_code", key_code, 4'd0);

    reset_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      check($sformatf("rotate_k%0d", k), col_out, col_tab[(k / SCAN_DIV) % 4]);
      cycles(1);
    end

    // Clean press of row 2 / column 1.
    code = model_code(1, 4'b0100);
    exp_q.push_back(code);
    last_code = code;
    press(1, 4'b0100);
    cycles(40);
    check("clean_pulse_consumed", exp_q.size(), 0);
    check("clean_held", key_held, 1'b1);
    check("clean_code", key_code, 4'b1001);
    pressed = '0;
    cycles(9);
    check("release_not_early", key_held, 1'b1);
    cycles(4);
    check("release_done", key_held, 1'b0);

    // Bouncing contact on row 0 / column 0.
    for (int i = 0; i < 5; i++) begin
      press(0, 4'b0001);
      cycles(3);
      pressed = '0;
      cycles(3);
    end
    seen = 4'b0000;
    for (int i = 0; i < 24; i++) begin
      for (int c = 0; c < 4; c++) if (col_out == col_tab[c]) seen[c] = 1'b1;
      cycles(1);
    end
    check("bounce_scan_resumes", seen, 4'hF);
    check("bounce_not_held", key_held, 1'b0);
    check("bounce_code_kept", key_code, last_code);

    // Two keys on column 2, rows 1 and 3.
    code = model_code(2, 4'b1010);
    exp_q.push_back(code);
    last_code = code;
    press(2, 4'b1010);
    cycles(40);
    check("two_key_held", key_held, 1'b1);
    check("two_key_code", key_code, 4'b0110);
    pressed = '0;
    cycles(20);
    check("two_key_released", key_held, 1'b0);

    // Long hold: one pulse, or auto-repeat pulses when enabled.
    pulse_t.delete();
    exp_off.push_back(0);
`ifdef KEYPAD_REPEAT_EN
    off = RDLY;
    while (off < 100) begin
      exp_off.push_back(off);
      off += RPER;
    end
`endif
    code = model_code(3, 4'b0001);
    foreach (exp_off[i]) exp_q.push_back(code);
    last_code = code;
    press(3, 4'b0001);
    for (int i = 0; i < 60 && key_valid !== 1'b1; i++) cycles(1);
    check("repeat_first_pulse_seen", key_valid, 1'b1);
    cycles(100);
    pressed = '0;
    cycles(20);
    check("repeat_pulse_count", pulse_t.size(), exp_off.size());
    for (int i = 0; i < exp_off.size() && i < pulse_t.size(); i++)
      check($sformatf("repeat_offset_%0d", i), pulse_t[i] - pulse_t[0], exp_off[i]);

    // Reset during debounce.
    press(1, 4'b0010);
    cycles(9);
    #2 reset_n = 1'b0;
    #1;
    check("mid_deb_rst_col", col_out, 4'b1110);
    check("mid_deb_rst_valid", key_valid, 1'b0);
    check("mid_deb_rst_code", key_code, 4'd0);
    last_code = 4'd0;
    pressed = '0;
    cycles(2);
    reset_n = 1'b1;
    check("restart_col0", col_out, 4'b1110);
    cycles(4);
    check("restart_col1", col_out, 4'b1101);

    // Reset while a key is held.
    code = model_code(1, 4'b1000);
    exp_q.push_back(code);
    press(1, 4'b1000);
    for (int i = 0; i < 60 && key_held !== 1'b1; i++) cycles(1);
    check("mid_hold_reached", key_held, 1'b1);
    cycles(3);
    #2 reset_n = 1'b0;
    #1;
    check("mid_hold_rst_col", col_out, 4'b1110);
    check("mid_hold_rst_held", key_held, 1'b0);
    check("mid_hold_rst_valid", key_valid, 1'b0);
    check("mid_hold_rst_code", key_code, 4'd0);
    last_code = 4'd0;
    pressed = '0;
    cycles(2);
    reset_n = 1'b1;
    cycles(20);

    // Randomized clean presses and bounces.
    for (int t = 0; t < 10; t++) begin
      cycles($urandom_range(20, 40));
      col  = $urandom_range(0, 3);
      mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) begin
        code = model_code(col, mask);
        exp_q.push_back(code);
        last_code = code;
        press(col, mask);
        cycles(35);
        check($sformatf("rand%0d_held", t), key_held, 1'b1);
        cycles(9);
        pressed = '0;
      end else begin
        for (int i = 0; i < 5; i++) begin
          press(col, mask);
          cycles(3);
          pressed = '0;
          cycles(3);
        end
      end
      cycles(20);
      check($sformatf("rand%0d_released", t), key_held, 1'b0);
      check($sformatf("rand%0d_code", t), key_code, last_code);
    end

    cycles(10);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
